// File: rtl/q_serial_tx.sv
// ============================================================================
// Module   : q_serial_tx
// Brief    : Frames the 4-bit Q result bus onto an idle-high serial line
//            (start, 4 data bits LSB first, optional even parity, stop).
//            Define Q_TX_PARITY_EN to insert the parity bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module q_serial_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] Q,
    input  logic       TX_EN,
    output logic       TX_BUSY,
    output logic       TX_DONE,
    output logic       TXD
);

    localparam logic [7:0] c_BAUD_LAST = 8'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef Q_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t     r_state;
    logic [7:0] r_baud_cnt;
    logic [1:0] r_bit_idx;
    logic [3:0] r_shift;
    logic       r_txd;
    logic       r_busy;
    logic       r_done;
    logic       w_bit_end;
`ifdef Q_TX_PARITY_EN
    logic       r_parity;
`endif

    assign w_bit_end = (r_baud_cnt == c_BAUD_LAST);

    // TXD is the registered value for the state being entered, so the line
    // moves on the same edge as the state transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= 8'd0;
            r_bit_idx  <= 2'd0;
            r_shift    <= 4'd0;
            r_txd      <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef Q_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_txd  <= 1'b1;
                    r_busy <= 1'b0;
                    if (TX_EN) begin
                        r_shift    <= Q;
`ifdef Q_TX_PARITY_EN
                        r_parity   <= ^Q;
`endif
                        r_state    <= S_START;
                        r_txd      <= 1'b0;
                        r_busy     <= 1'b1;
                        r_baud_cnt <= 8'd0;
                        r_bit_idx  <= 2'd0;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= 8'd0;
                        r_state    <= S_DATA;
                        r_txd      <= r_shift[0];
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 8'd1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= 8'd0;
                        r_shift    <= r_shift >> 1;
                        r_bit_idx  <= r_bit_idx + 2'd1;
                        if (r_bit_idx == 2'd3) begin
`ifdef Q_TX_PARITY_EN
                            r_state <= S_PARITY;
                            r_txd   <= r_parity;
`else
                            r_state <= S_STOP;
                            r_txd   <= 1'b1;
`endif
                        end else begin
                            r_txd <= r_shift[1];
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 8'd1;
                    end
                end
`ifdef Q_TX_PARITY_EN
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= 8'd0;
                        r_state    <= S_STOP;
                        r_txd      <= 1'b1;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 8'd1;
                    end
                end
`endif
                S_STOP: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= 8'd0;
                        r_state    <= S_IDLE;
                        r_txd      <= 1'b1;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_baud_cnt <= 8'd0;
                    r_txd      <= 1'b1;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign TXD     = r_txd;
    assign TX_BUSY = r_busy;
    assign TX_DONE = r_done;

endmodule

`default_nettype wire

// File: tb/tb_q_serial_tx.sv
// ============================================================================
// Module   : tb_q_serial_tx
// Brief    : Self-checking bench for q_serial_tx against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_q_serial_tx;

    localparam int CPB = 4;
`ifdef Q_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int NBITS = PAR ? 7 : 6;
    localparam int FLEN  = NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] Q;
    logic       TX_EN;
    logic       TX_BUSY;
    logic       TX_DONE;
    logic       TXD;

    int tests  = 0;
    int failed = 0;

    q_serial_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk     (clk),
        .rst     (rst),
        .Q       (Q),
        .TX_EN   (TX_EN),
        .TX_BUSY (TX_BUSY),
        .TX_DONE (TX_DONE),
        .TXD     (TXD)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame model: bit slot j of the frame for data word q.
    function automatic logic exp_bit(input logic [3:0] q, input int j);
        if (j == 0) return 1'b0;
        if (j <= 4) return q[j-1];
        if (PAR && j == 5) return ^q;
        return 1'b1;
    endfunction

    // Called from inside an idle (or TX_DONE) cycle; returns inside the
    // TX_DONE cycle of the frame it sent, with TX_EN left at 'hold'.
    task automatic send_frame(input logic [3:0] q, input bit hold);
        Q     = q;
        TX_EN = 1'b1;
        tick();
        for (int k = 1; k <= FLEN; k++) begin
            check($sformatf("txd[q=%0h,c=%0d]", q, k), {3'b0, TXD},
                  {3'b0, exp_bit(q, (k - 1) / CPB)});
            check($sformatf("busy[c=%0d]", k), {3'b0, TX_BUSY}, 4'd1);
            check($sformatf("done_early[c=%0d]", k), {3'b0, TX_DONE}, 4'd0);
            Q     = 4'($urandom);
            TX_EN = hold ? 1'b1 : 1'($urandom);
            if (k == 10) begin
                Q     = 4'hF;
                TX_EN = 1'b1;
            end
            tick();
        end
        check($sformatf("done[q=%0h]", q), {3'b0, TX_DONE}, 4'd1);
        check("busy_at_done", {3'b0, TX_BUSY}, 4'd0);
        check("txd_at_done", {3'b0, TXD}, 4'd1);
        TX_EN = hold;
    endtask

    task automatic idle_check(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            tick();
            check("idle_txd", {3'b0, TXD}, 4'd1);
            check("idle_busy", {3'b0, TX_BUSY}, 4'd0);
            check("idle_done", {3'b0, TX_DONE}, 4'd0);
        end
    endtask

    initial begin
        rst   = 1'b1;
        TX_EN = 1'b0;
        Q     = 4'h0;
        tick();
        tick();
        check("rst_txd", {3'b0, TXD}, 4'd1);
        check("rst_busy", {3'b0, TX_BUSY}, 4'd0);
        check("rst_done", {3'b0, TX_DONE}, 4'd0);
        rst = 1'b0;
        idle_check(20);

        // Directed frames from the plan
        send_frame(4'b1010, 1'b0);
        idle_check(2);
        send_frame(4'b0111, 1'b0);
        idle_check(1);
        send_frame(4'b0011, 1'b0);
        idle_check(1);
        send_frame(4'h5, 1'b0);
        idle_check(3);

        // Back-to-back with TX_EN held high
        send_frame(4'h3, 1'b1);
        send_frame(4'hC, 1'b1);
        TX_EN = 1'b0;
        idle_check(2);

        // Randomized words, some sent back-to-back
        for (int n = 0; n < 10; n++) begin
            send_frame(4'($urandom), 1'($urandom));
        end
        TX_EN = 1'b0;
        idle_check(1);

        // Reset in the middle of a frame
        Q     = 4'($urandom);
        TX_EN = 1'b1;
        tick();
        TX_EN = 1'b0;
        repeat (11) tick();
        check("mid_busy_before_rst", {3'b0, TX_BUSY}, 4'd1);
        rst = 1'b1;
        tick();
        check("abort_txd", {3'b0, TXD}, 4'd1);
        check("abort_busy", {3'b0, TX_BUSY}, 4'd0);
        check("abort_done", {3'b0, TX_DONE}, 4'd0);
        rst = 1'b0;
        idle_check(2 * FLEN);
        send_frame(4'b1001, 1'b0);
        TX_EN = 1'b0;
        idle_check(3);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
